// File: rtl/ssd_scan_ctrl_pkg.sv
// Shared constants and types for the seven-segment scan controller.
// Pin polarities are active-low throughout.
package ssd_scan_ctrl_pkg;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic       AN_OFF    = 1'b1;
  localparam logic       AN_ON     = 1'b0;
  localparam logic       DP_OFF    = 1'b1;
  localparam logic       DP_ON     = 1'b0;

  typedef enum logic {
    ST_DEAD  = 1'b0,
    ST_DRIVE = 1'b1
  } slot_state_e;

endpackage

// File: rtl/ssd_scan_ctrl_ssd_driver.sv
// Hex nibble to seven-segment decoder, segments {g..a}, active-low.
module ssd_scan_ctrl_ssd_driver (
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  always_comb begin
    seg = 7'h7F;
    case (nibble)
      4'h0: seg = 7'h40;
      4'h1: seg = 7'h79;
      4'h2: seg = 7'h24;
      4'h3: seg = 7'h30;
      4'h4: seg = 7'h19;
      4'h5: seg = 7'h12;
      4'h6: seg = 7'h02;
      4'h7: seg = 7'h78;
      4'h8: seg = 7'h00;
      4'h9: seg = 7'h10;
      4'hA: seg = 7'h08;
      4'hB: seg = 7'h03;
      4'hC: seg = 7'h46;
      4'hD: seg = 7'h21;
      4'hE: seg = 7'h06;
      4'hF: seg = 7'h0E;
      default: seg = 7'h7F;
    endcase
  end

endmodule

// File: rtl/ssd_scan_ctrl.sv
// Time-multiplexed scan controller for a common-anode seven-segment display:
// one digit per slot, dead-time blanking at slot start, optional leading-zero blanking.
module ssd_scan_ctrl
  import ssd_scan_ctrl_pkg::*;
#(
  parameter int NUM_DIGITS  = 4,
  parameter int SLOT_CYCLES = 100000,
  parameter int DEAD_CYCLES = 8,
  localparam int IDX_W      = $clog2(NUM_DIGITS),
  localparam int CNT_W      = $clog2(SLOT_CYCLES)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic                    load,
  input  logic                    lz_en,
  input  logic [NUM_DIGITS-1:0]   dp_mask,
  output logic [NUM_DIGITS-1:0]   an,
  output logic [6:0]              seg,
  output logic                    dp,
  output logic [IDX_W-1:0]        slot_idx
);

  logic [4*NUM_DIGITS-1:0] shadow;
  logic [CNT_W-1:0]        slot_cnt;
  logic [IDX_W-1:0]        cur_idx;
  logic                    slot_last;
  slot_state_e             slot_state;
  logic [3:0]              nibble;
  logic [6:0]              dec_seg;
  logic [NUM_DIGITS-1:0]   zero_prefix;
  logic                    blank;
  logic [NUM_DIGITS-1:0]   an_d;
  logic [6:0]              seg_d;
  logic                    dp_d;

  assign slot_last = (slot_cnt == CNT_W'(SLOT_CYCLES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow   <= '0;
      slot_cnt <= '0;
      cur_idx  <= '0;
    end else begin
      if (load) shadow <= value;
      if (slot_last) begin
        slot_cnt <= '0;
        cur_idx  <= (cur_idx == IDX_W'(NUM_DIGITS - 1)) ? '0 : cur_idx + 1'b1;
      end else begin
        slot_cnt <= slot_cnt + 1'b1;
      end
    end
  end

  // Slot phase is a pure function of the slot counter; it has no storage of its own.
  always_comb begin
    slot_state = (slot_cnt < CNT_W'(DEAD_CYCLES)) ? ST_DEAD : ST_DRIVE;
  end

  always_comb begin
    nibble = 4'h0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (cur_idx == IDX_W'(k)) nibble = shadow[4*k +: 4];
    end
  end

  // zero_prefix[k]: digit k and every digit above it are zero.
  always_comb begin
    zero_prefix = '0;
    zero_prefix[NUM_DIGITS-1] = (shadow[4*(NUM_DIGITS-1) +: 4] == 4'h0);
    for (int k = NUM_DIGITS - 2; k >= 0; k--) begin
      zero_prefix[k] = zero_prefix[k+1] && (shadow[4*k +: 4] == 4'h0);
    end
  end

  assign blank = lz_en && zero_prefix[cur_idx] && (cur_idx != '0);

  ssd_scan_ctrl_ssd_driver u_ssd_driver (
    .nibble (nibble),
    .seg    (dec_seg)
  );

  always_comb begin
    an_d  = {NUM_DIGITS{AN_OFF}};
    seg_d = SEG_BLANK;
    dp_d  = DP_OFF;
    case (slot_state)
      ST_DRIVE: begin
        an_d[cur_idx] = AN_ON;
        seg_d         = blank ? SEG_BLANK : dec_seg;
        dp_d          = dp_mask[cur_idx] ? DP_ON : DP_OFF;
      end
      default: begin
        an_d  = {NUM_DIGITS{AN_OFF}};
        seg_d = SEG_BLANK;
        dp_d  = DP_OFF;
      end
    endcase
  end

  // slot_idx is delayed with the pins so it always names the digit on the bus.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      an       <= {NUM_DIGITS{AN_OFF}};
      seg      <= SEG_BLANK;
      dp       <= DP_OFF;
      slot_idx <= '0;
    end else begin
      an       <= an_d;
      seg      <= seg_d;
      dp       <= dp_d;
      slot_idx <= cur_idx;
    end
  end

endmodule

// File: tb/tb_ssd_scan_ctrl.sv
// Bench for ssd_scan_ctrl: fixed digit vectors, multi-cycle corner sequences,
// and randomized traffic checked against a cycle-count based display model.
module tb_ssd_scan_ctrl;

  localparam int ND   = 4;
  localparam int SLOT = 10;
  localparam int DEAD = 2;

  logic        clk;
  logic        rst_n;
  logic [15:0] value;
  logic        load;
  logic        lz_en;
  logic [3:0]  dp_mask;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;
  logic [1:0]  slot_idx;

  ssd_scan_ctrl #(
    .NUM_DIGITS  (ND),
    .SLOT_CYCLES (SLOT),
    .DEAD_CYCLES (DEAD)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .value    (value),
    .load     (load),
    .lz_en    (lz_en),
    .dp_mask  (dp_mask),
    .an       (an),
    .seg      (seg),
    .dp       (dp),
    .slot_idx (slot_idx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  logic [6:0] hex_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  // Model: edges since reset release and the word most recently loaded.
  int          cyc;
  logic [15:0] m_shadow;
  int          last_cnt;
  int          last_idx;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    int cnt, idx;
    logic [3:0] ea;
    logic [6:0] es;
    logic       ed;
    cnt = cyc % SLOT;
    idx = (cyc / SLOT) % ND;
    ea = 4'hF;
    es = 7'h7F;
    ed = 1'b1;
    if (cnt >= DEAD) begin
      ea = ~(4'b0001 << idx);
      if (lz_en && idx != 0 && (m_shadow >> (4 * idx)) == 16'h0)
        es = 7'h7F;
      else
        es = hex_tab[(m_shadow >> (4 * idx)) & 16'hF];
      ed = ~dp_mask[idx];
    end
    @(posedge clk);
    cyc++;
    if (load) m_shadow = value;
    #1;
    chk("scan_pins", {18'h0, an, seg, dp, slot_idx}, {18'h0, ea, es, ed, 2'(idx)});
    chk("an_onehot", 32'($countones(~an) <= 1), 32'd1);
    last_cnt = cnt;
    last_idx = idx;
  endtask

  task automatic do_load(input logic [15:0] v);
    value = v;
    load  = 1'b1;
    step();
    load  = 1'b0;
  endtask

  typedef struct {
    logic [15:0] value;
    logic        lz;
    logic [3:0]  dpm;
    int          digit;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp;
  } vec_t;

  vec_t vecs [12];

  initial begin
    bit found;
    vecs[0]  = '{16'h1A3F, 1'b0, 4'b0000, 0, 4'b1110, 7'h0E, 1'b1};
    vecs[1]  = '{16'h1A3F, 1'b0, 4'b0000, 1, 4'b1101, 7'h30, 1'b1};
    vecs[2]  = '{16'h1A3F, 1'b0, 4'b0000, 2, 4'b1011, 7'h08, 1'b1};
    vecs[3]  = '{16'h1A3F, 1'b0, 4'b0000, 3, 4'b0111, 7'h79, 1'b1};
    vecs[4]  = '{16'h0040, 1'b1, 4'b0000, 3, 4'b0111, 7'h7F, 1'b1};
    vecs[5]  = '{16'h0040, 1'b1, 4'b0000, 2, 4'b1011, 7'h7F, 1'b1};
    vecs[6]  = '{16'h0040, 1'b1, 4'b0000, 1, 4'b1101, 7'h19, 1'b1};
    vecs[7]  = '{16'h0040, 1'b1, 4'b0000, 0, 4'b1110, 7'h40, 1'b1};
    vecs[8]  = '{16'h0000, 1'b1, 4'b0000, 1, 4'b1101, 7'h7F, 1'b1};
    vecs[9]  = '{16'h0000, 1'b1, 4'b0000, 0, 4'b1110, 7'h40, 1'b1};
    vecs[10] = '{16'h8888, 1'b0, 4'b0100, 2, 4'b1011, 7'h00, 1'b0};
    vecs[11] = '{16'h8888, 1'b0, 4'b0100, 1, 4'b1101, 7'h00, 1'b1};

    rst_n = 1'b0; value = '0; load = 1'b0; lz_en = 1'b0; dp_mask = '0;
    cyc = 0; m_shadow = '0; last_cnt = 0; last_idx = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_pins", {18'h0, an, seg, dp, slot_idx}, {18'h0, 4'hF, 7'h7F, 1'b1, 2'd0});
    rst_n = 1'b1;

    // Table: load word, wait for mid-DRIVE of the target digit, compare.
    foreach (vecs[i]) begin
      lz_en   = vecs[i].lz;
      dp_mask = vecs[i].dpm;
      do_load(vecs[i].value);
      found = 1'b0;
      for (int n = 0; n < 8 * SLOT && !found; n++) begin
        step();
        if (last_cnt == DEAD + 1 && last_idx == vecs[i].digit) begin
          found = 1'b1;
          chk($sformatf("vec%0d_an", i), 32'(an), 32'(vecs[i].an));
          chk($sformatf("vec%0d_seg", i), 32'(seg), 32'(vecs[i].seg));
          chk($sformatf("vec%0d_dp", i), 32'(dp), 32'(vecs[i].dp));
        end
      end
      chk($sformatf("vec%0d_reached", i), 32'(found), 32'd1);
    end

    // Mid-slot asynchronous reset, then the restart delay.
    lz_en = 1'b0; dp_mask = '0;
    repeat (SLOT + 4) step();
    #3;
    rst_n = 1'b0;
    #1;
    chk("async_reset_pins", {18'h0, an, seg, dp, slot_idx}, {18'h0, 4'hF, 7'h7F, 1'b1, 2'd0});
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cyc = 0;
    m_shadow = '0;
    step();
    chk("restart_dead0", 32'(an), 32'hF);
    step();
    chk("restart_dead1", 32'(an), 32'hF);
    step();
    chk("restart_drive_an", 32'(an), 32'b1110);
    chk("restart_drive_seg", 32'(seg), 32'h40);

    // Load coinciding with the terminal count of a slot.
    do_load(16'h1234);
    for (int n = 0; n < SLOT && (cyc % SLOT) != SLOT - 1; n++) step();
    do_load(16'h8888);
    repeat (DEAD) step();
    chk("tc_load_dead", 32'(an), 32'hF);
    step();
    chk("tc_load_seg", 32'(seg), 32'h00);

    // Randomized traffic against the model.
    for (int n = 0; n < 500; n++) begin
      logic [15:0] v;
      for (int k = 0; k < 4; k++)
        v[4*k +: 4] = ($urandom_range(0, 2) == 0) ? 4'h0 : 4'($urandom_range(0, 15));
      value = v;
      load  = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 19) == 0) lz_en = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 19) == 0) dp_mask = 4'($urandom_range(0, 15));
      step();
    end
    load = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
